data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, the byte address width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, the number of consecutive denied external-request cycles before the external requester is forced a grant; legal range 1-15.

Interface
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  MEM-stage access request, asserted for loads or stores.
REQ-007 cpu_we  in  1  MEM-stage store (1) or load (0).
REQ-008 cpu_addr  in  ADDR_WIDTH  MEM-stage address (ALU result).
REQ-009 cpu_wdata  in  DATA_WIDTH  MEM-stage store data.
REQ-010 cpu_rdata  out  DATA_WIDTH  load data to the MEM/WB register.
REQ-011 cpu_stall  out  1  freeze the PC and all pipeline registers this cycle.
REQ-012 ext_req  in  1  external (port/loader) access request, held until granted.
REQ-013 ext_we  in  1  external write (1) or read (0).
REQ-014 ext_addr  in  ADDR_WIDTH  external address.
REQ-015 ext_wdata  in  DATA_WIDTH  external write data.
REQ-016 ext_gnt  out  1  external access accepted this cycle.
REQ-017 ext_rdata  out  DATA_WIDTH  registered external read data.
REQ-018 ext_rvalid  out  1  one-cycle pulse qualifying ext_rdata.
REQ-019 mem_read, mem_write  out  1 each  data-memory strobes.
REQ-020 mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_rdata  in  DATA_WIDTH  data-memory port (combinational read, synchronous write).
REQ-021 owner  out  2  registered owner of the previous cycle: 00 none, 01 CPU, 10 EXT.

Function
REQ-022 Exactly zero or one requester SHALL be granted per cycle; the grant decision SHALL be combinational from current inputs and the wait counter.
REQ-023 Grant rule: EXT is granted if ext_req is high and (cpu_req is low or wait_cnt == MAX_WAIT); otherwise CPU is granted if cpu_req is high.
REQ-024 wait_cnt (4 bits) SHALL increment when ext_req is high and ext_gnt is low, saturate at MAX_WAIT, and clear to 0 on ext_gnt or when ext_req is low.
REQ-025 cpu_stall SHALL equal cpu_req AND NOT CPU-granted.
REQ-026 Memory-side outputs SHALL be driven from the granted requester: mem_addr/mem_wdata from its address/data, mem_write = granted we, mem_read = granted NOT we; with no grant, all mem_* outputs SHALL be 0.
REQ-027 A denied requester SHALL never cause mem_write to assert; a stalled CPU store SHALL write only in the cycle it is granted.
REQ-028 cpu_rdata SHALL equal mem_rdata when CPU is granted with cpu_we low, else 0 (zero added latency).
REQ-029 On a granted EXT read, ext_rdata SHALL capture mem_rdata at the clock edge and ext_rvalid SHALL be 1 for exactly the next cycle; ext_rdata SHALL hold until the next EXT read.
REQ-030 EXT writes SHALL produce no ext_rvalid pulse.
REQ-031 Back-to-back EXT grants SHALL be allowed only when cpu_req is low; after a forced EXT grant the CPU SHALL win the next contended cycle (wait_cnt is 0).
REQ-032 owner SHALL register the granted requester each cycle.

Reset
REQ-033 While reset is low: wait_cnt = 0, ext_rvalid = 0, ext_rdata = 0, owner = 00, asynchronously.
REQ-034 An EXT read granted in the cycle reset asserts SHALL produce no ext_rvalid pulse after reset releases.
REQ-035 Combinational outputs SHALL follow REQ-023..REQ-028 from the reset state, so that with reset low and only cpu_req high, CPU is granted and cpu_stall is 0.

Verification
REQ-036 CPU-only load, cpu_addr=0x10010004, mem_rdata=0xDEADBEEF -> mem_read=1, cpu_rdata=0xDEADBEEF same cycle, cpu_stall=0, owner=01 next cycle.
REQ-037 cpu_req and ext_req held high, MAX_WAIT=4 -> CPU granted cycles 1-4, wait_cnt 1..4; cycle 5 ext_gnt=1, cpu_stall=1; cycle 6 CPU granted, wait_cnt=0.
REQ-038 EXT read alone, ext_addr=0x20, mem_rdata=0x12345678 -> ext_gnt=1 same cycle; next cycle ext_rvalid=1, ext_rdata=0x12345678; following cycle ext_rvalid=0.
REQ-039 CPU store stalled by forced EXT write -> exactly one mem_write with ext_wdata, then one mem_write with cpu_wdata on the next cycle; no other write pulses.
REQ-040 Reset asserted during the cycle of an EXT read grant -> ext_rvalid stays 0, wait_cnt=0, owner=00 after release.
REQ-041 No requests for 10 cycles -> all mem_* outputs 0, ext_gnt=0, cpu_stall=0, owner=00.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and an external requester.
// EXT wins when the CPU is idle or after MAX_WAIT consecutive denied cycles.
module data_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,

  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ext_rvalid,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic [1:0]            owner
);

  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  cpu_gnt;
  logic                  ext_rvalid_q;
  logic [DATA_WIDTH-1:0] ext_rdata_q;
  logic [1:0]            owner_q;

  always_comb begin
    ext_gnt   = ext_req & (~cpu_req | (wait_cnt_q == MaxWaitCnt));
    cpu_gnt   = cpu_req & ~ext_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // Only the granted side reaches the memory; a denied store never strobes mem_write.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ext_gnt) begin
      mem_read  = ~ext_we;
      mem_write = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (cpu_gnt) begin
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    cpu_rdata = (cpu_gnt & ~cpu_we) ? mem_rdata : '0;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ext_req || ext_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MaxWaitCnt) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= 4'd0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
      owner_q      <= 2'b00;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_gnt & ~ext_we;
      owner_q      <= {ext_gnt, cpu_gnt};
      if (ext_gnt && !ext_we) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter; inputs change 1ns after the rising edge,
// combinational outputs are sampled 1ns later, registered ones just after the edge.
module tb_data_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_gnt, ext_rvalid;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    owner;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_WAIT  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_gnt   (ext_gnt),
    .ext_rdata (ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    mem_rdata = '0;
  endtask

  // Both requesters held high; gnt_at is the cycle EXT must win (0 = never).
  task automatic contend(input string tag, input int n_cycles, input int gnt_at);
    for (int c = 1; c <= n_cycles; c++) begin
      #1;
      chk($sformatf("%s_gnt%0d", tag, c), 64'(ext_gnt), 64'(c == gnt_at));
      chk($sformatf("%s_stall%0d", tag, c), 64'(cpu_stall), 64'(c == gnt_at));
      tick();
      chk($sformatf("%s_owner%0d", tag, c), 64'(owner), (c == gnt_at) ? 64'd2 : 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wr;

    // Reset held low: combinational path still serves a lone CPU request.
    idle_inputs();
    reset   = 1'b0;
    cpu_req = 1'b1;
    #3;
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_read", 64'(mem_read), 64'd1);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_rvalid", 64'(ext_rvalid), 64'd0);
    chk("rst_rdata", 64'(ext_rdata), 64'd0);
    cpu_req = 1'b0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ctl", 64'({mem_read, mem_write, ext_gnt, cpu_stall, owner}), 64'd0);
      chk("idle_bus", {mem_addr, mem_wdata}, 64'd0);
    end

    // CPU-only load.
    cpu_req   = 1'b1;
    cpu_addr  = 32'h1001_0004;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_read", 64'(mem_read), 64'd1);
    chk("ld_addr", 64'(mem_addr), 64'h1001_0004);
    chk("ld_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    chk("ld_stall", 64'(cpu_stall), 64'd0);
    tick();
    chk("ld_owner", 64'(owner), 64'd1);

    // CPU-only store: no load data returned.
    cpu_we    = 1'b1;
    cpu_wdata = 32'hCAFE_0001;
    #1;
    chk("st_write", 64'({mem_read, mem_write}), 64'b01);
    chk("st_wdata", 64'(mem_wdata), 64'hCAFE_0001);
    chk("st_rdata", 64'(cpu_rdata), 64'd0);
    tick();
    idle_inputs();
    tick();

    // Sustained contention: EXT forced on cycle 5, CPU wins cycle 6.
    cpu_req  = 1'b1;
    cpu_addr = 32'h100;
    ext_req  = 1'b1;
    ext_we   = 1'b1;
    ext_addr = 32'h40;
    contend("cont", 6, 5);
    idle_inputs();
    tick();

    // EXT read alone.
    ext_req   = 1'b1;
    ext_addr  = 32'h20;
    mem_rdata = 32'h1234_5678;
    #1;
    chk("er_gnt", 64'(ext_gnt), 64'd1);
    chk("er_read", 64'({mem_read, mem_write}), 64'b10);
    chk("er_addr", 64'(mem_addr), 64'h20);
    tick();
    ext_req   = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("er_rvalid1", 64'(ext_rvalid), 64'd1);
    chk("er_rdata1", 64'(ext_rdata), 64'h1234_5678);
    chk("er_owner", 64'(owner), 64'd2);
    tick();
    chk("er_rvalid2", 64'(ext_rvalid), 64'd0);
    chk("er_hold", 64'(ext_rdata), 64'h1234_5678);
    idle_inputs();
    tick();

    // CPU store stalled by a forced EXT write, then written on the next cycle.
    n_wr      = 0;
    ext_wdata = 32'hAAAA_5555;
    cpu_wdata = 32'h1111_2222;
    ext_we    = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cpu_req = (c <= 6);
      cpu_we  = (c == 5 || c == 6);
      ext_req = (c <= 5);
      #1;
      if (mem_write) n_wr++;
      chk($sformatf("sw_write%0d", c), 64'(mem_write), 64'(c == 5 || c == 6));
      if (c == 5) begin
        chk("sw_ext_data", 64'(mem_wdata), 64'hAAAA_5555);
        chk("sw_stall", 64'(cpu_stall), 64'd1);
      end
      if (c == 6) begin
        chk("sw_cpu_data", 64'(mem_wdata), 64'h1111_2222);
        chk("sw_no_rvalid", 64'(ext_rvalid), 64'd0);
      end
      tick();
    end
    chk("sw_count", 64'(n_wr), 64'd2);
    idle_inputs();
    tick();

    // Reset lands in the cycle of an EXT read grant.
    ext_req   = 1'b1;
    ext_addr  = 32'h30;
    mem_rdata = 32'h0000_0055;
    #1;
    chk("rg_gnt", 64'(ext_gnt), 64'd1);
    #2;
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    ext_req = 1'b0;
    #1;
    chk("rg_rvalid", 64'(ext_rvalid), 64'd0);
    chk("rg_owner", 64'(owner), 64'd0);
    chk("rg_rdata", 64'(ext_rdata), 64'h1234_5678 & 64'd0);
    tick();
    chk("rg_rvalid2", 64'(ext_rvalid), 64'd0);

    // Partial wait count must be cleared by an asynchronous reset pulse.
    cpu_req = 1'b1;
    ext_req = 1'b1;
    ext_we  = 1'b1;
    contend("pre", 3, 0);
    #2;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    chk("rp_owner", 64'(owner), 64'd0);
    contend("post", 5, 5);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
